carrack_pad_exerciser: RTL and testbench

//  Wishbone-controlled pad test sequencer; opposite end of the fastio control-pin loopback.
//  Per channel it drives an OE and an OUT control pin and samples the pad under test.
//  A 16-bit LFSR supplies the patterns. Every driven pad is compared against its expected

---
 rtl/carrack_pad_exerciser.sv | 208 ++++++++++++++++++++
 tb/tb_carrack_pad_exerciser.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/carrack_pad_exerciser.sv
`timescale 1ns/1ps
// Wishbone-controlled pad test sequencer: drives per-channel OE/OUT control
// pins from a 16-bit LFSR, samples the pads back and records mismatches.
// Ports: wbs_* Wishbone slave (regs at adr[4:2]), ctl_oe_o/ctl_out_o pad
// controls, pad_in_i asynchronous pad inputs, irq_o = done & irq_en.
module carrack_pad_exerciser #(
  parameter int CH          = 8,
  parameter int SETTLE      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [31:0]   wbs_adr_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic [CH-1:0] ctl_oe_o,
  output logic [CH-1:0] ctl_out_o,
  input  logic [CH-1:0] pad_in_i,
  output logic          irq_o
);

  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DRIVE, ST_SETL, ST_SAMPLE, ST_DONE
  } state_e;

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     seed_q, seed_d;
  logic [15:0]     steps_q, steps_d;
  logic [15:0]     errcnt_q, errcnt_d;
  logic [CH-1:0]   errmask_q, errmask_d;
  logic [15:0]     stepidx_q, stepidx_d;
  logic            irq_en_q, irq_en_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [CH-1:0]   oe_q, oe_d;
  logic [CH-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CH-1:0]   sync_q [SYNC_STAGES];

  logic            req, wr, rd, wr_ctrl, start, abort, busy;
  logic [2:0]      sel;
  logic [31:0]     rdata;
  logic [CH-1:0]   mism;
  logic [15:0]     lfsr_nx;
  logic            unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:5],
                       wbs_adr_i[1:0], wbs_dat_i[31:16]};

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign ctl_oe_o  = oe_q;
  assign ctl_out_o = out_q;
  assign irq_o     = done_q & irq_en_q;

  always_comb begin
    req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    wr      = req & wbs_we_i;
    rd      = req & ~wbs_we_i;
    sel     = wbs_adr_i[4:2];
    wr_ctrl = wr && (sel == 3'd0);
    start   = wr_ctrl & wbs_dat_i[0];
    abort   = wr_ctrl & wbs_dat_i[1];
    busy    = (state_q != ST_IDLE);
    // Only driven channels can mismatch.
    mism    = oe_q & (sync_q[SYNC_STAGES-1] ^ out_q);
    lfsr_nx = {lfsr_q[14:0],
               lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rdata   = '0;
    case (sel)
      3'd0: rdata = {29'd0, irq_en_q, 2'b00};
      3'd1: rdata = {29'd0, err_q, done_q, busy};
      3'd2: rdata = {16'd0, seed_q};
      3'd3: rdata = {16'd0, steps_q};
      3'd4: rdata = {16'd0, errcnt_q};
      3'd5: rdata = {{(32-CH){1'b0}}, errmask_q};
      3'd6: rdata = {16'd0, stepidx_q};
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = req;
    dat_d     = rd ? rdata : '0;
    lfsr_d    = lfsr_q;
    seed_d    = seed_q;
    steps_d   = steps_q;
    errcnt_d  = errcnt_q;
    errmask_d = errmask_q;
    stepidx_d = stepidx_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    err_d     = err_q;
    oe_d      = oe_q;
    out_d     = out_q;
    cnt_d     = cnt_q;

    if (wr_ctrl) irq_en_d = wbs_dat_i[2];
    if (wr && sel == 3'd2 && !busy) seed_d = wbs_dat_i[15:0];
    if (wr && sel == 3'd3 && !busy) steps_d = wbs_dat_i[15:0];
    // W1C first so a same-cycle set in ST_DONE wins.
    if (wr && sel == 3'd1 && wbs_dat_i[1]) done_d = 1'b0;

    if (abort && busy) begin
      state_d = ST_IDLE;
      oe_d    = '0;
      out_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            lfsr_d    = (seed_q == 16'd0) ? 16'hACE1 : seed_q;
            errcnt_d  = '0;
            errmask_d = '0;
            stepidx_d = '0;
            err_d     = 1'b0;
            done_d    = 1'b0;
            state_d   = (steps_q == 16'd0) ? ST_DONE : ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          oe_d    = lfsr_q[CH-1:0];
          out_d   = lfsr_q[2*CH-1:CH];
          cnt_d   = CW'(SETTLE - 1);
          state_d = ST_SETL;
        end
        ST_SETL: begin
          if (cnt_q == '0) state_d = ST_SAMPLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_SAMPLE: begin
          errmask_d = errmask_q | mism;
          if (|mism) begin
            err_d = 1'b1;
            if (errcnt_q != 16'hFFFF) errcnt_d = errcnt_q + 16'd1;
          end
          lfsr_d    = lfsr_nx;
          stepidx_d = stepidx_q + 16'd1;
          if (stepidx_q + 16'd1 == steps_q) begin
            state_d = ST_DONE;
            oe_d    = '0;
            out_d   = '0;
          end else begin
            state_d = ST_DRIVE;
          end
        end
        ST_DONE: begin
          oe_d    = '0;
          out_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      dat_q     <= '0;
      lfsr_q    <= '0;
      seed_q    <= '0;
      steps_q   <= '0;
      errcnt_q  <= '0;
      errmask_q <= '0;
      stepidx_q <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      oe_q      <= '0;
      out_q     <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      lfsr_q    <= lfsr_d;
      seed_q    <= seed_d;
      steps_q   <= steps_d;
      errcnt_q  <= errcnt_d;
      errmask_q <= errmask_d;
      stepidx_q <= stepidx_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      sync_q[0] <= pad_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_carrack_pad_exerciser.sv
`timescale 1ns/1ps
// Scoreboarded directed bench for carrack_pad_exerciser.
// Bus reads queue their expected data; a negedge monitor checks each ack.
module tb_carrack_pad_exerciser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack, irq;
  logic [31:0] dat_o;
  logic [7:0]  oe, out, pad, junk;
  logic        stuck3 = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          chk;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  always @(posedge clk) junk <= 8'($urandom);

  // Loopback: driven channels echo OUT, undriven ones float (random).
  assign pad = ((oe & out) | (~oe & junk)) & (stuck3 ? 8'hF7 : 8'hFF);

  carrack_pad_exerciser dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(dat_i),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_o),
    .ctl_oe_o (oe),
    .ctl_out_o(out),
    .pad_in_i (pad),
    .irq_o    (irq)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  logic ack_prev = 1'b0;
  always @(negedge clk) begin
    if (ack) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_ack: got ack, expected none");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check({e.name, "_ack_1cyc"}, {31'd0, ack_prev}, 32'd0);
        if (e.chk) check(e.name, dat_o, e.exp);
      end
    end
    ack_prev <= ack;
  end

  task automatic wb(input logic w, input logic [2:0] a,
                    input logic [31:0] d, input string nm,
                    input logic [31:0] exp, input bit chk);
    sbq.push_back('{nm, exp, chk});
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w;
    adr = {27'd0, a, 2'b00}; dat_i = d;
    @(posedge clk);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wb(1'b1, a, d, "wr", 32'd0, 1'b0);
  endtask

  task automatic rd(input string nm, input logic [2:0] a,
                    input logic [31:0] exp);
    wb(1'b0, a, 32'd0, nm, exp, 1'b1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  // Steps where channel 3 is driven high (stuck-at-0 pad mismatches).
  function automatic int stuck3_hits(input logic [15:0] s, input int n);
    logic [15:0] l;
    int c;
    l = s;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (l[3] & l[11]) c++;
      l = lfsr_step(l);
    end
    return c;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;

    cycles(3);
    @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_oe_out", {16'd0, oe, out}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    rd("rst_status", 3'd1, 32'd0);
    rd("rst_seed", 3'd2, 32'd0);

    // 1: ideal loopback, 100 steps, irq disabled
    wr(3'd2, 32'd1);
    wr(3'd3, 32'd100);
    wr(3'd0, 32'd1);
    cycles(610);
    rd("t1_status", 3'd1, 32'd2);
    rd("t1_errcnt", 3'd4, 32'd0);
    rd("t1_errmask", 3'd5, 32'd0);
    rd("t1_stepidx", 3'd6, 32'd100);
    check("t1_irq_off", {31'd0, irq}, 32'd0);
    wr(3'd0, 32'd4);
    check("t1_irq_on", {31'd0, irq}, 32'd1);
    rd("t1_ctrl", 3'd0, 32'd4);
    wr(3'd1, 32'd2);
    check("t1_irq_w1c", {31'd0, irq}, 32'd0);
    rd("t1_status_w1c", 3'd1, 32'd0);

    // 2: channel 3 stuck at 0
    stuck3 = 1'b1;
    hits = stuck3_hits(16'h1234, 200);
    wr(3'd2, 32'h1234);
    wr(3'd3, 32'd200);
    wr(3'd0, 32'd1);
    cycles(1210);
    rd("t2_status", 3'd1, 32'd6);
    rd("t2_errcnt", 3'd4, 32'(hits));
    rd("t2_errmask", 3'd5, (hits > 0) ? 32'h08 : 32'h00);
    rd("t2_stepidx", 3'd6, 32'd200);
    stuck3 = 1'b0;

    // 3: zero steps
    wr(3'd3, 32'd0);
    wr(3'd0, 32'd1);
    check("t3_oe_out", {16'd0, oe, out}, 32'd0);
    rd("t3_status", 3'd1, 32'd2);
    check("t3_oe_out_after", {16'd0, oe, out}, 32'd0);
    rd("t3_errcnt", 3'd4, 32'd0);
    rd("t3_errmask", 3'd5, 32'd0);

    // seed 0 is replaced by ACE1 on load
    wr(3'd2, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("seed0_drive", {16'd0, oe, out}, 32'h0000_E1AC);
    cycles(10);
    rd("seed0_seed", 3'd2, 32'd0);

    // 4: abort during step 10 of 100
    wr(3'd2, 32'h1234);
    wr(3'd3, 32'd100);
    wr(3'd0, 32'd1);
    cycles(61);
    wr(3'd0, 32'd2);
    check("t4_oe_out", {16'd0, oe, out}, 32'd0);
    rd("t4_status", 3'd1, 32'd0);
    rd("t4_stepidx", 3'd6, 32'd10);
    wr(3'd0, 32'd1);
    cycles(610);
    rd("t4_rerun_status", 3'd1, 32'd2);
    rd("t4_rerun_errcnt", 3'd4, 32'd0);
    rd("t4_rerun_stepidx", 3'd6, 32'd100);

    // 5: reset mid-run
    wr(3'd2, 32'd5);
    wr(3'd0, 32'd5);
    cycles(20);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_oe_out", {16'd0, oe, out}, 32'd0);
    check("t5_ack_dat", {31'd0, ack} | dat_o, 32'd0);
    check("t5_irq", {31'd0, irq}, 32'd0);
    rst = 1'b0;
    rd("t5_ctrl", 3'd0, 32'd0);
    rd("t5_status", 3'd1, 32'd0);
    rd("t5_seed", 3'd2, 32'd0);
    rd("t5_steps", 3'd3, 32'd0);
    rd("t5_stepidx", 3'd6, 32'd0);

    // 6: writes and restart while busy are ignored
    wr(3'd2, 32'h1234);
    wr(3'd3, 32'd20);
    wr(3'd0, 32'd1);
    wr(3'd3, 32'd50);
    wr(3'd2, 32'd9);
    wr(3'd0, 32'd1);
    cycles(116);
    rd("t6_status", 3'd1, 32'd2);
    rd("t6_steps", 3'd3, 32'd20);
    rd("t6_seed", 3'd2, 32'h1234);
    rd("t6_stepidx", 3'd6, 32'd20);
    rd("t6_unmapped", 3'd7, 32'd0);

    cycles(4);
    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
